btn_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 11 +
 rtl/btn_debounce_ch.sv | 61 ++++++
 rtl/btn_conditioner.sv | 45 ++++
 tb/tb_btn_conditioner.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning stage.
package btn_pkg;

   localparam int NUM_BTN = 3;

   // Bit positions of each button in the PRESS vector.
   localparam int IDX_A = 2;
   localparam int IDX_B = 1;
   localparam int IDX_C = 0;

endpackage : btn_pkg

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, persistence counter,
// clean level, and a one-cycle pulse when the level rises.
module btn_debounce_ch #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic RAW,
   output logic LVL,
   output logic PRESS
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             lvl_q;
   logic             lvl_d;
   logic             press_q;
   logic             press_d;

   // The counter only runs while s2 disagrees with the level, so any
   // agreeing edge throws away a partially accumulated excursion.
   always_comb begin
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      if (s2_q == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         lvl_d   = s2_q;
         cnt_d   = '0;
         press_d = s2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         press_q <= 1'b0;
      end else begin
         s1_q    <= RAW;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         press_q <= press_d;
      end
   end

   assign LVL   = lvl_q;
   assign PRESS = press_q;

endmodule : btn_debounce_ch

// File: rtl/btn_conditioner.sv
// Three independent debounced button channels feeding the control FSM:
// clean levels A/B/C plus rising-edge PRESS pulses.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_A,
   input  logic       BTN_B,
   input  logic       BTN_C,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic [2:0] PRESS
);

   logic [NUM_BTN-1:0] raw_w;
   logic [NUM_BTN-1:0] lvl_w;
   logic [NUM_BTN-1:0] press_w;

   assign raw_w[IDX_A] = BTN_A;
   assign raw_w[IDX_B] = BTN_B;
   assign raw_w[IDX_C] = BTN_C;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .CLK  (CLK),
         .RST  (RST),
         .RAW  (raw_w[gi]),
         .LVL  (lvl_w[gi]),
         .PRESS(press_w[gi])
      );
   end

   // Channel outputs are already flops, so these are plain wires.
   assign A     = lvl_w[IDX_A];
   assign B     = lvl_w[IDX_B];
   assign C     = lvl_w[IDX_C];
   assign PRESS = press_w;

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: vector table plus hand-written
// multi-cycle sequences, with a second instance at DEBOUNCE_CYCLES=1.
module tb_btn_conditioner;

   logic       CLK;
   logic       RST;
   logic       BTN_A, BTN_B, BTN_C;
   logic       A, B, C;
   logic [2:0] PRESS;

   logic       B1_A, B1_B, B1_C;
   logic       A1, B1, C1;
   logic [2:0] PRESS1;

   int total = 0;
   int bad   = 0;

   btn_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK(CLK), .RST(RST),
      .BTN_A(BTN_A), .BTN_B(BTN_B), .BTN_C(BTN_C),
      .A(A), .B(B), .C(C), .PRESS(PRESS)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
      .CLK(CLK), .RST(RST),
      .BTN_A(B1_A), .BTN_B(B1_B), .BTN_C(B1_C),
      .A(A1), .B(B1), .C(C1), .PRESS(PRESS1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst;
      logic [2:0] btn;
      logic [2:0] lvl;
      logic [2:0] press;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic [2:0] btn,
                               input logic [2:0] lvl, input logic [2:0] press);
      vec_t v;
      v.rst = rst; v.btn = btn; v.lvl = lvl; v.press = press;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%b exp=%b", name, got, exp);
      end else begin
         $display("ok   %s: %b", name, got);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1;
      {BTN_A, BTN_B, BTN_C} = 3'b000;
      {B1_A, B1_B, B1_C}    = 3'b000;

      // Reset with idle buttons, then with A held high.
      add(1, 3'b000, 3'b000, 3'b000);
      add(1, 3'b000, 3'b000, 3'b000);
      add(1, 3'b100, 3'b000, 3'b000);
      add(1, 3'b100, 3'b000, 3'b000);
      add(0, 3'b000, 3'b000, 3'b000);
      add(0, 3'b000, 3'b000, 3'b000);
      // Clean press on C: level after 6th edge, pulse only that cycle.
      for (int k = 1; k <= 7; k++)
         add(0, 3'b001, (k >= 6) ? 3'b001 : 3'b000, (k == 6) ? 3'b001 : 3'b000);
      // Release of C: no pulse.
      for (int k = 1; k <= 7; k++)
         add(0, 3'b000, (k >= 6) ? 3'b000 : 3'b001, 3'b000);
      // Simultaneous A and B.
      for (int k = 1; k <= 7; k++)
         add(0, 3'b110, (k >= 6) ? 3'b110 : 3'b000, (k == 6) ? 3'b110 : 3'b000);
      for (int k = 1; k <= 7; k++)
         add(0, 3'b000, (k >= 6) ? 3'b000 : 3'b110, 3'b000);

      for (int i = 0; i < vecs.size(); i++) begin
         RST = vecs[i].rst;
         {BTN_A, BTN_B, BTN_C} = vecs[i].btn;
         step();
         check($sformatf("vec%0d lvl", i), {A, B, C}, vecs[i].lvl);
         check($sformatf("vec%0d press", i), PRESS, vecs[i].press);
      end

      // Bounce on B: high runs of at most 3 edges never flip the level.
      begin
         logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
         for (int i = 0; i < 9; i++) begin
            BTN_B = pat[i];
            step();
            check($sformatf("bounce%0d lvl", i), {A, B, C}, 3'b000);
            check($sformatf("bounce%0d press", i), PRESS, 3'b000);
         end
      end
      BTN_B = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         check($sformatf("bhold%0d lvl", k), {A, B, C}, (k >= 6) ? 3'b010 : 3'b000);
         check($sformatf("bhold%0d press", k), PRESS, (k == 6) ? 3'b010 : 3'b000);
      end
      BTN_B = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         check($sformatf("brel%0d lvl", k), {A, B, C}, (k >= 6) ? 3'b000 : 3'b010);
      end

      // Reset mid-count on A: edge 5 lands with cnt=2.
      BTN_A = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("midcnt%0d lvl", k), {A, B, C}, 3'b000);
      end
      RST = 1'b1;
      step();
      check("midrst lvl", {A, B, C}, 3'b000);
      check("midrst press", PRESS, 3'b000);
      RST = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         check($sformatf("postrst%0d lvl", k), {A, B, C}, (k >= 6) ? 3'b100 : 3'b000);
         check($sformatf("postrst%0d press", k), PRESS, (k == 6) ? 3'b100 : 3'b000);
      end
      BTN_A = 1'b0;
      for (int k = 1; k <= 7; k++) step();
      check("arel lvl", {A, B, C}, 3'b000);

      // DEBOUNCE_CYCLES=1 instance: level 3 edges after the raw rise.
      B1_A = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         check($sformatf("n1_%0d lvl", k), {A1, B1, C1}, (k >= 3) ? 3'b100 : 3'b000);
         check($sformatf("n1_%0d press", k), PRESS1, (k == 3) ? 3'b100 : 3'b000);
      end
      B1_A = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("n1rel%0d lvl", k), {A1, B1, C1}, (k >= 3) ? 3'b000 : 3'b100);
         check($sformatf("n1rel%0d press", k), PRESS1, 3'b000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_btn_conditioner
